// File: rtl/shift_rotate_if.sv
// -----------------------------------------------------------------------------
// shift_rotate_if
// Purpose : request/response bundle between a datapath sequencer (master) and
//           the multi-cycle shift/rotate unit (slave).
// Signals :
//   start    master->slave  request, sampled only while the unit is idle
//   op       master->slave  3'b000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL,
//                           101..111 pass-through
//   data_in  master->slave  operand (Y / Rb path)
//   amount   master->slave  shift count, AW bits (0..WIDTH-1)
//   busy     slave->master  high whenever the unit is not idle
//   done     slave->master  one-cycle completion pulse
//   result   slave->master  shifted/rotated value toward ZLow (held)
//   carry    slave->master  last bit shifted out / rotate carry (held)
//   zero     slave->master  result == 0 (held)
// -----------------------------------------------------------------------------
interface shift_rotate_if #(
    parameter int WIDTH = 32
) ();
    localparam int AW = $clog2(WIDTH);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [AW-1:0]    amount;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;

    modport master (
        output start, op, data_in, amount,
        input  busy, done, result, carry, zero
    );

    modport slave (
        input  start, op, data_in, amount,
        output busy, done, result, carry, zero
    );
endinterface

// File: rtl/shift_rotate_unit.sv
// -----------------------------------------------------------------------------
// shift_rotate_unit
// Purpose : multi-cycle SHR/SHRA/SHL/ROR/ROL unit. At most STEP bit positions
//           are shifted per clock so no full-width barrel shifter sits on the
//           critical path; results go toward ZLow with carry and zero flags.
// Ports   :
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high clear; aborts any operation in flight
//   bus   slave modport of shift_rotate_if (start/op/data_in/amount in,
//         busy/done/result/carry/zero out, all outputs registered)
// Parameters:
//   WIDTH  datapath width (>=2, power of two)
//   STEP   max bit positions shifted per clock (1..WIDTH)
// -----------------------------------------------------------------------------
module shift_rotate_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic           clk,
    input  logic           rst,
    shift_rotate_if.slave  bus
);
    localparam int AW = $clog2(WIDTH);
    localparam logic [AW:0] STEP_W = (AW+1)'(STEP);

    localparam logic [2:0] OP_SHR  = 3'd0;
    localparam logic [2:0] OP_SHRA = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Per-step shifter: one candidate per legal step size, selected below.
    logic [AW:0]      step_s;
    logic [AW:0]      rem_after_s;
    logic [WIDTH-1:0] shift_tbl_s [0:STEP];
    logic             shift_cy_tbl_s [0:STEP];
    logic [WIDTH-1:0] shifted_s;
    logic             step_carry_s;
    logic             final_carry_s;

    // Step size s = min(STEP, remaining) and the remaining count after it.
    always_comb begin
        step_s = {1'b0, rem_q};
        if ({1'b0, rem_q} > STEP_W) begin
            step_s = STEP_W;
        end else begin
            step_s = {1'b0, rem_q};
        end
        rem_after_s = {1'b0, rem_q} - step_s;
    end

    // Build the STEP+1 constant-distance shift candidates for the latched op.
    // Each candidate also records the last bit it pushes out.
    always_comb begin
        shift_tbl_s[0]    = work_q;
        shift_cy_tbl_s[0] = 1'b0;
        for (int k = 1; k <= STEP; k++) begin
            case (op_q)
                OP_SHR: begin
                    shift_tbl_s[k]    = work_q >> k;
                    shift_cy_tbl_s[k] = work_q[k-1];
                end
                OP_SHRA: begin
                    // Arithmetic shift keeps the original MSB across steps.
                    shift_tbl_s[k]    = $unsigned($signed(work_q) >>> k);
                    shift_cy_tbl_s[k] = work_q[k-1];
                end
                OP_SHL: begin
                    shift_tbl_s[k]    = work_q << k;
                    shift_cy_tbl_s[k] = work_q[WIDTH-k];
                end
                OP_ROR: begin
                    shift_tbl_s[k]    = (work_q >> k) | (work_q << (WIDTH-k));
                    shift_cy_tbl_s[k] = 1'b0;
                end
                OP_ROL: begin
                    shift_tbl_s[k]    = (work_q << k) | (work_q >> (WIDTH-k));
                    shift_cy_tbl_s[k] = 1'b0;
                end
                default: begin
                    shift_tbl_s[k]    = work_q;
                    shift_cy_tbl_s[k] = 1'b0;
                end
            endcase
        end
        shifted_s    = shift_tbl_s[step_s];
        step_carry_s = shift_cy_tbl_s[step_s];
    end

    // Carry reported at completion: shifts keep the last bit pushed out,
    // rotates report the wrapped-in edge bit of the final result.
    always_comb begin
        case (op_q)
            OP_ROR:  final_carry_s = shifted_s[WIDTH-1];
            OP_ROL:  final_carry_s = shifted_s[0];
            OP_SHR,
            OP_SHRA,
            OP_SHL:  final_carry_s = step_carry_s;
            default: final_carry_s = 1'b0;
        endcase
    end

    // Next-state and datapath update for IDLE -> RUN -> DONE sequencing.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        rem_d    = rem_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d   = bus.op;
                    work_d = bus.data_in;
                    if ((bus.amount == '0) || (bus.op > OP_ROL)) begin
                        // Nothing to shift: the operand is the result.
                        state_d  = ST_DONE;
                        rem_d    = '0;
                        result_d = bus.data_in;
                        carry_d  = 1'b0;
                        zero_d   = (bus.data_in == '0);
                    end else begin
                        state_d = ST_RUN;
                        rem_d   = bus.amount;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                work_d = shifted_s;
                rem_d  = rem_after_s[AW-1:0];
                if (rem_after_s == '0) begin
                    state_d  = ST_DONE;
                    result_d = shifted_s;
                    carry_d  = final_carry_s;
                    zero_d   = (shifted_s == '0);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered output flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= 3'd0;
            work_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            op_q     <= op_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_rotate_unit
// Scoreboard bench for shift_rotate_unit (WIDTH=32, STEP=4). Expected results
// come from a direct single-shot reference model and are queued at request
// time, then popped when done pulses.
// -----------------------------------------------------------------------------
module tb_shift_rotate_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    shift_rotate_if #(.WIDTH(32)) bus ();

    shift_rotate_unit #(.WIDTH(32), .STEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] result;
        logic        carry;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: one full-distance operation, no stepping.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a);
        exp_t        e;
        logic [31:0] r;
        logic        c;
        int          ai;
        ai = int'(a);
        r  = d;
        c  = 1'b0;
        if (ai != 0) begin
            case (op)
                3'd0: begin r = d >> ai; c = d[ai-1]; end
                3'd1: begin r = $unsigned($signed(d) >>> ai); c = d[ai-1]; end
                3'd2: begin r = d << ai; c = d[32-ai]; end
                3'd3: begin r = (d >> ai) | (d << (32-ai)); c = r[31]; end
                3'd4: begin r = (d << ai) | (d >> (32-ai)); c = r[0]; end
                default: begin r = d; c = 1'b0; end
            endcase
        end
        e.result = r;
        e.carry  = c;
        e.zero   = (r == 32'd0);
        return e;
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [4:0] a);
        if (a == 5'd0 || op > 3'd4) return 0;
        return (int'(a) + 3) / 4;
    endfunction

    // One request: accept, wait for done, check latency/result/pulse width.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] d, input logic [4:0] a);
        exp_t e;
        exp_t got;
        int   cyc;
        int   lat;
        lat = model_lat(op, a);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.data_in = d; bus.amount = a;
        exp_q.push_back(model(op, d, a));
        @(negedge clk);
        // Scramble the inputs so a unit that fails to latch them is exposed.
        bus.start = 1'b0; bus.op = 3'd7; bus.data_in = ~d; bus.amount = a ^ 5'd7;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, bus.done, cyc);
            void'(exp_q.pop_front());
        end else begin
            checks++;
            if (cyc !== lat) begin
                errors++;
                $display("FAIL %s latency: got %0d required %0d", name, cyc, lat);
            end
            got = {bus.result, bus.carry, bus.zero};
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s result/carry/zero: got %h/%b/%b required %h/%b/%b",
                         name, got.result, got.carry, got.zero, e.result, e.carry, e.zero);
            end
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy during done: got %b required 1", name, bus.busy);
            end
            @(negedge clk);
            checks++;
            if ({bus.done, bus.busy, bus.result} !== {1'b0, 1'b0, e.result}) begin
                errors++;
                $display("FAIL %s after done: done=%b busy=%b result=%h required 0/0/%h",
                         name, bus.done, bus.busy, bus.result, e.result);
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b1; bus.op = 3'd2; bus.data_in = 32'h1234_5678; bus.amount = 5'd3;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.result, bus.carry, bus.zero} !== 35'd0) begin
            errors++;
            $display("FAIL reset outputs: busy=%b done=%b result=%h carry=%b zero=%b required all 0",
                     bus.busy, bus.done, bus.result, bus.carry, bus.zero);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset start ignored: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_directed();
        do_op("ror_7",     3'd3, 32'h0000_0002, 5'd7);
        do_op("shra_5",    3'd1, 32'h8000_0010, 5'd5);
        do_op("rol_1",     3'd4, 32'h8000_0001, 5'd1);
        do_op("shr_1",     3'd0, 32'h0000_0001, 5'd1);
        do_op("shl_4",     3'd2, 32'h0F00_000F, 5'd4);
        do_op("ror_31",    3'd3, 32'h8000_0000, 5'd31);
        do_op("rol_31",    3'd4, 32'h0000_0001, 5'd31);
        do_op("shra_31",   3'd1, 32'h7FFF_FFFF, 5'd31);
        do_op("pass_op6",  3'd6, 32'hCAFE_F00D, 5'd9);
        do_op("shr_amt0",  3'd0, 32'hDEAD_BEEF, 5'd0);
    endtask

    task automatic test_shl_busy();
        exp_t e;
        exp_t got;
        int   busy_cnt;
        int   done_cnt;
        busy_cnt = 0; done_cnt = 0; got = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd2; bus.data_in = 32'h0000_0001; bus.amount = 5'd31;
        exp_q.push_back(model(3'd2, 32'h0000_0001, 5'd31));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            // Keep start asserted with new data while busy: must be ignored.
            if (i == 0) begin
                bus.data_in = 32'hFFFF_FFFF; bus.amount = 5'd1;
            end
            if (i == 3) bus.start = 1'b0;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                got = {bus.result, bus.carry, bus.zero};
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (busy_cnt !== 9) begin
            errors++;
            $display("FAIL shl31 busy cycles: got %0d required 9", busy_cnt);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL shl31 done pulses: got %0d required 1", done_cnt);
        end
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL shl31 result: got %h/%b/%b required %h/%b/%b",
                     got.result, got.carry, got.zero, e.result, e.carry, e.zero);
        end
    endtask

    task automatic test_zero_amount();
        exp_t e;
        int   done_cnt;
        done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.data_in = 32'hDEAD_BEEF; bus.amount = 5'd0;
        exp_q.push_back(model(3'd4, 32'hDEAD_BEEF, 5'd0));
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({bus.done, bus.result, bus.carry, bus.zero} !== {1'b1, e.result, e.carry, e.zero}) begin
            errors++;
            $display("FAIL amt0 done: done=%b result=%h carry=%b zero=%b required 1/%h/%b/%b",
                     bus.done, bus.result, bus.carry, bus.zero, e.result, e.carry, e.zero);
        end
        // start still high through the DONE cycle with a different operand.
        bus.data_in = 32'h0000_0000; bus.amount = 5'd3;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL amt0 start-in-done ignored: busy=%b done=%b required 0/0", bus.busy, bus.done);
        end
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
        checks++;
        if ({done_cnt, bus.result} !== {32'd0, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL amt0 extra pulses/hold: pulses=%0d result=%h required 0/deadbeef", done_cnt, bus.result);
        end
    endtask

    task automatic test_clear_midrun();
        int done_cnt;
        done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd2; bus.data_in = 32'h0000_00FF; bus.amount = 5'd20;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL clear pre-busy: busy=%b required 1", bus.busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.result, bus.carry, bus.zero} !== 35'd0) begin
            errors++;
            $display("FAIL clear async: busy=%b done=%b result=%h carry=%b zero=%b required all 0",
                     bus.busy, bus.done, bus.result, bus.carry, bus.zero);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL clear abort: %0d busy/done cycles after clear, required 0", done_cnt);
        end
        do_op("ror_after_clear", 3'd3, 32'h0000_0001, 5'd1);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.data_in = 32'hF0F0_0000; bus.amount = 5'd9;
        exp_q.push_back(model(3'd0, 32'hF0F0_0000, 5'd9));
        cyc = 0;
        @(negedge clk);
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.done, bus.result, bus.carry, cyc} !== {1'b1, e.result, e.carry, 32'd3}) begin
            errors++;
            $display("FAIL b2b first: done=%b result=%h carry=%b lat=%0d required 1/%h/%b/3",
                     bus.done, bus.result, bus.carry, cyc, e.result, e.carry);
        end
        // start stays high; second request is only taken once back in IDLE.
        bus.op = 3'd4; bus.data_in = 32'h1234_5678; bus.amount = 5'd12;
        exp_q.push_back(model(3'd4, 32'h1234_5678, 5'd12));
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b idle gap: busy=%b required 0", bus.busy);
        end
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.done, bus.result, bus.carry, bus.zero, cyc} !== {1'b1, e.result, e.carry, e.zero, 32'd3}) begin
            errors++;
            $display("FAIL b2b second: done=%b result=%h carry=%b zero=%b lat=%0d required 1/%h/%b/%b/3",
                     bus.done, bus.result, bus.carry, bus.zero, cyc, e.result, e.carry, e.zero);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] d;
        logic [4:0]  a;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            d  = $urandom;
            a  = 5'($urandom_range(0, 31));
            do_op("random", op, d, a);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 3'd0; bus.data_in = 32'd0; bus.amount = 5'd0;
        test_reset();
        test_directed();
        test_shl_busy();
        test_zero_amount();
        test_clear_midrun();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
